// File: rtl/cache_pkg.sv
`timescale 1ns/1ps
// Shared geometry, FSM encodings and the latched-request type for the data cache.
package cache_pkg;

  localparam int NUM_SETS    = 128;
  localparam int NUM_WAYS    = 4;
  localparam int BLOCK_WORDS = 4;
  localparam int MEM_LATENCY = 4;

  localparam int TAG_W  = 21;
  localparam int IDX_W  = 7;
  localparam int OFF_W  = 4;
  localparam int WAY_W  = $clog2(NUM_WAYS);
  localparam int WORD_W = $clog2(BLOCK_WORDS);
  localparam int AGE_W  = $clog2(NUM_WAYS);
  localparam int CNT_W  = $clog2(MEM_LATENCY);
  localparam int LINE_AW = IDX_W + WAY_W + WORD_W;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_LATENCY - 1);

  localparam logic [2:0] S_IDLE       = 3'b000;
  localparam logic [2:0] S_READ_HIT   = 3'b001;
  localparam logic [2:0] S_READ_MISS  = 3'b010;
  localparam logic [2:0] S_WRITE_HIT  = 3'b011;
  localparam logic [2:0] S_WRITE_MISS = 3'b100;
  localparam logic [2:0] S_EVICT      = 3'b101;
  localparam logic [2:0] S_ALLOCATE   = 3'b110;

  typedef struct packed {
    logic [TAG_W-1:0]  tag;
    logic [IDX_W-1:0]  idx;
    logic [WORD_W-1:0] word;
    logic              rw;
    logic [31:0]       data;
  } req_t;

  // The memory stub holds no data: a filled word is its own byte address.
  function automatic logic [31:0] fill_word(input logic [TAG_W-1:0] tag,
                                            input logic [IDX_W-1:0] idx,
                                            input logic [WORD_W-1:0] w);
    return {tag, idx, w, 2'b00};
  endfunction

endpackage

// File: rtl/cache_lru.sv
`timescale 1ns/1ps
// True-LRU age tracking: one 2-bit age per way per set, age 0 = most recently used.
// Touching a previously invalid way ages every other way, keeping valid ways' ages distinct.
module cache_lru
  import cache_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic [IDX_W-1:0] set_i,
  output logic [WAY_W-1:0] victim_o,
  input  logic             touch_i,
  input  logic [IDX_W-1:0] touch_set_i,
  input  logic [WAY_W-1:0] touch_way_i,
  input  logic             touch_valid_i
);

  logic [NUM_WAYS-1:0][AGE_W-1:0] rd_age;
  logic [NUM_WAYS-1:0][AGE_W-1:0] tch_age;
  logic [AGE_W-1:0]               old_age;

  assign old_age = touch_valid_i ? tch_age[touch_way_i] : '1;

  generate
    for (genvar gi = 0; gi < NUM_WAYS; gi++) begin : g_age
      logic [AGE_W-1:0] age_q [NUM_SETS];

      assign rd_age[gi]  = age_q[set_i];
      assign tch_age[gi] = age_q[touch_set_i];

      always_ff @(posedge clk) begin
        if (rst) begin
          for (int s = 0; s < NUM_SETS; s++) begin
            age_q[s] <= '0;
          end
        end else if (touch_i) begin
          if (touch_way_i == WAY_W'(gi)) begin
            age_q[touch_set_i] <= '0;
          end else if (tch_age[gi] < old_age) begin
            age_q[touch_set_i] <= tch_age[gi] + AGE_W'(1);
          end
        end
      end
    end
  endgenerate

  always_comb begin
    victim_o = '0;
    for (int w = NUM_WAYS - 1; w >= 0; w--) begin
      if (rd_age[w] == '1) begin
        victim_o = WAY_W'(w);
      end
    end
  end

endmodule

// File: rtl/cache_controller.sv
`timescale 1ns/1ps
// 4-way set-associative write-back / write-allocate data cache in front of a data-less memory stub.
// A request is any change of {address,rw}; completion is a one-cycle ready pulse.
module cache_controller
  import cache_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] address,
  input  logic [31:0] data_in,
  input  logic        rw,
  output logic [31:0] data_out,
  output logic        ready
);

  logic [2:0]       current_state;
  logic [2:0]       state_d;
  req_t             req_q;
  logic [WAY_W-1:0] way_q;
  logic             vic_valid_q;
  logic [CNT_W-1:0] count_q;
  logic             pending_q;
  logic [29:0]      prev_addr_q;
  logic             prev_rw_q;
  logic [31:0]      data_out_q;

  logic [TAG_W-1:0]                  tag_q [NUM_SETS][NUM_WAYS];
  logic [NUM_SETS-1:0][NUM_WAYS-1:0] valid_q;
  logic [NUM_SETS-1:0][NUM_WAYS-1:0] dirty_q;
  logic [31:0]                       data_q [NUM_SETS*NUM_WAYS*BLOCK_WORDS];

  logic [TAG_W-1:0]    in_tag;
  logic [IDX_W-1:0]    in_idx;
  logic                change;
  logic                accept;
  logic                hit_any;
  logic                last_fill;
  logic                touch;
  logic [NUM_WAYS-1:0] hit_vec;
  logic [NUM_WAYS-1:0] inv_vec;
  logic [WAY_W-1:0]    hit_way;
  logic [WAY_W-1:0]    inv_way;
  logic [WAY_W-1:0]    lru_victim;
  logic [WAY_W-1:0]    victim;
  logic [LINE_AW-1:0]  word_addr;
  logic                unused_addr;

  assign in_tag      = address[OFF_W+IDX_W +: TAG_W];
  assign in_idx      = address[OFF_W +: IDX_W];
  assign unused_addr = ^address[1:0];
  assign word_addr   = {req_q.idx, way_q, req_q.word};

  assign change = (address[31:2] != prev_addr_q) || (rw != prev_rw_q);
  assign accept = (current_state == S_IDLE) && (change || pending_q);

  generate
    for (genvar gi = 0; gi < NUM_WAYS; gi++) begin : g_way
      assign hit_vec[gi] = valid_q[in_idx][gi] && (tag_q[in_idx][gi] == in_tag);
      assign inv_vec[gi] = ~valid_q[req_q.idx][gi];
    end
  endgenerate

  // Descending scan so the lowest matching index wins.
  always_comb begin
    hit_way = '0;
    inv_way = '0;
    for (int w = NUM_WAYS - 1; w >= 0; w--) begin
      if (hit_vec[w]) hit_way = WAY_W'(w);
      if (inv_vec[w]) inv_way = WAY_W'(w);
    end
  end

  assign hit_any   = |hit_vec;
  assign victim    = (|inv_vec) ? inv_way : lru_victim;
  assign last_fill = (current_state == S_ALLOCATE) && (count_q == CNT_LAST);
  assign touch     = (current_state == S_READ_HIT) || (current_state == S_WRITE_HIT) || last_fill;
  assign ready     = touch;
  assign data_out  = data_out_q;

  cache_lru u_lru (
    .clk           (clk),
    .rst           (rst),
    .set_i         (req_q.idx),
    .victim_o      (lru_victim),
    .touch_i       (touch),
    .touch_set_i   (req_q.idx),
    .touch_way_i   (way_q),
    .touch_valid_i (last_fill ? vic_valid_q : 1'b1)
  );

  always_comb begin
    state_d = current_state;
    case (current_state)
      S_IDLE: begin
        if (accept) begin
          if (hit_any) state_d = rw ? S_WRITE_HIT : S_READ_HIT;
          else         state_d = rw ? S_WRITE_MISS : S_READ_MISS;
        end
      end
      S_READ_HIT, S_WRITE_HIT: state_d = S_IDLE;
      S_READ_MISS, S_WRITE_MISS: begin
        if (valid_q[req_q.idx][victim] && dirty_q[req_q.idx][victim]) state_d = S_EVICT;
        else                                                          state_d = S_ALLOCATE;
      end
      S_EVICT:    if (count_q == CNT_LAST) state_d = S_ALLOCATE;
      S_ALLOCATE: if (last_fill) state_d = S_IDLE;
      default:    state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      current_state <= S_IDLE;
      req_q         <= '0;
      way_q         <= '0;
      vic_valid_q   <= 1'b0;
      count_q       <= '0;
      pending_q     <= 1'b0;
      prev_addr_q   <= '0;
      prev_rw_q     <= 1'b0;
      data_out_q    <= '0;
    end else begin
      current_state <= state_d;
      prev_addr_q   <= address[31:2];
      prev_rw_q     <= rw;

      if (accept)      pending_q <= 1'b0;
      else if (change) pending_q <= 1'b1;

      if (accept) begin
        req_q.tag  <= in_tag;
        req_q.idx  <= in_idx;
        req_q.word <= address[3:2];
        req_q.rw   <= rw;
        req_q.data <= data_in;
        way_q      <= hit_way;
      end

      if (current_state == S_READ_MISS || current_state == S_WRITE_MISS) begin
        way_q       <= victim;
        vic_valid_q <= valid_q[req_q.idx][victim];
      end

      if ((current_state == S_EVICT || current_state == S_ALLOCATE) && state_d == current_state)
        count_q <= count_q + CNT_W'(1);
      else
        count_q <= '0;

      if (current_state == S_READ_HIT)
        data_out_q <= data_q[word_addr];
      else if (last_fill && !req_q.rw)
        data_out_q <= fill_word(req_q.tag, req_q.idx, req_q.word);
    end
  end

  always_ff @(posedge clk) begin
    if (current_state == S_WRITE_HIT) begin
      data_q[word_addr] <= req_q.data;
    end
    if (last_fill) begin
      tag_q[req_q.idx][way_q] <= req_q.tag;
      for (int i = 0; i < BLOCK_WORDS; i++) begin
        data_q[{req_q.idx, way_q, WORD_W'(i)}] <=
          (req_q.rw && req_q.word == WORD_W'(i)) ? req_q.data
                                                 : fill_word(req_q.tag, req_q.idx, WORD_W'(i));
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
      dirty_q <= '0;
    end else if (last_fill) begin
      valid_q[req_q.idx][way_q] <= 1'b1;
      dirty_q[req_q.idx][way_q] <= req_q.rw;
    end else if (current_state == S_WRITE_HIT) begin
      dirty_q[req_q.idx][way_q] <= 1'b1;
    end
  end

endmodule

// File: tb/tb_cache_controller.sv
`timescale 1ns/1ps
// Directed bench for cache_controller: hit/miss/evict sequence, pending requests and mid-access reset.
module tb_cache_controller;
  import cache_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] address;
  logic [31:0] data_in;
  logic        rw;
  logic [31:0] data_out;
  logic        ready;

  int total = 0;
  int bad   = 0;
  int accesses = 0;
  int hits     = 0;

  always #5 clk = ~clk;

  cache_controller dut (
    .clk      (clk),
    .rst      (rst),
    .address  (address),
    .data_in  (data_in),
    .rw       (rw),
    .data_out (data_out),
    .ready    (ready)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Counts rising edges until ready is sampled high; lat = -1 if the bound expires.
  task automatic wait_ready(input int limit, output int lat, output logic [2:0] st);
    lat = -1;
    st  = '0;
    for (int i = 1; i <= limit; i++) begin
      @(posedge clk); #1;
      if (ready) begin
        lat = i;
        st  = dut.current_state;
        break;
      end
    end
  endtask

  task automatic access(input logic [31:0] a, input logic w, input logic [31:0] d,
                        output int lat, output logic [2:0] st, output logic [31:0] dout);
    @(negedge clk);
    address = a;
    rw      = w;
    data_in = d;
    wait_ready(40, lat, st);
    @(posedge clk); #1;
    dout = data_out;
    accesses++;
    if (lat == 1) hits++;
    $display("access addr=0x%08h rw=%0d data_in=0x%08h latency=%0d state=%0d data_out=0x%08h",
             a, w, d, lat, st, dout);
  endtask

  int          lat;
  logic [2:0]  st;
  logic [31:0] dout;

  initial begin
    rst = 1'b1; address = '0; rw = 1'b0; data_in = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_state",    32'(dut.current_state), 32'(S_IDLE));
    chk("rst_ready",    32'(ready), 32'd0);
    chk("rst_data_out", data_out, 32'h0);
    rst = 1'b0;

    wait_ready(8, lat, st);
    chk("idle_no_ready", 32'(lat), 32'hFFFF_FFFF);

    access(32'h8000_0000, 1'b1, 32'h1234_5678, lat, st, dout);
    chk("wmiss0_lat", 32'(lat), 32'd5);
    chk("wmiss0_st",  32'(st),  32'(S_ALLOCATE));

    access(32'h8000_0000, 1'b0, 32'h0, lat, st, dout);
    chk("rhit0_lat",  32'(lat), 32'd1);
    chk("rhit0_st",   32'(st),  32'(S_READ_HIT));
    chk("rhit0_data", dout, 32'h1234_5678);

    access(32'h8000_0004, 1'b1, 32'hAABB_CCDD, lat, st, dout);
    chk("whit1_lat", 32'(lat), 32'd1);
    chk("whit1_st",  32'(st),  32'(S_WRITE_HIT));

    access(32'h8000_0004, 1'b0, 32'h0, lat, st, dout);
    chk("rhit1_lat",  32'(lat), 32'd1);
    chk("rhit1_data", dout, 32'hAABB_CCDD);

    access(32'h8000_8000, 1'b1, 32'h1111_1111, lat, st, dout);
    chk("fill_w1_lat", 32'(lat), 32'd5);
    access(32'h8001_0000, 1'b1, 32'h2222_2222, lat, st, dout);
    chk("fill_w2_lat", 32'(lat), 32'd5);
    access(32'h8001_8000, 1'b1, 32'h3333_3333, lat, st, dout);
    chk("fill_w3_lat", 32'(lat), 32'd5);

    // Set 0 full; LRU way 0 is dirty, so this miss pays a write-back first.
    access(32'h8002_0000, 1'b1, 32'h4444_4444, lat, st, dout);
    chk("evict_w0_lat", 32'(lat), 32'd9);
    chk("evict_w0_st",  32'(st),  32'(S_ALLOCATE));

    access(32'h8000_0000, 1'b0, 32'h0, lat, st, dout);
    chk("evict_w1_lat",  32'(lat), 32'd9);
    chk("evict_w1_data", dout, 32'h8000_0000);

    chk("seq_accesses", 32'(accesses), 32'd9);
    chk("seq_hits",     32'(hits),     32'd3);
    chk("seq_hit_rate_x100", 32'((hits * 10000) / accesses), 32'd3333);

    access(32'h8000_0008, 1'b0, 32'h0, lat, st, dout);
    chk("stub_hit_lat",  32'(lat), 32'd1);
    chk("stub_hit_data", dout, 32'h8000_0008);

    wait_ready(12, lat, st);
    chk("no_reexec", 32'(lat), 32'hFFFF_FFFF);

    access(32'h8001_0004, 1'b0, 32'h0, lat, st, dout);
    chk("w2_stub_lat",  32'(lat), 32'd1);
    chk("w2_stub_data", dout, 32'h8001_0004);
    access(32'h8001_0000, 1'b0, 32'h0, lat, st, dout);
    chk("w2_dirty_data", dout, 32'h2222_2222);

    // Change the request while a miss is in flight; it must run afterwards.
    @(negedge clk);
    address = 32'h0000_0010; rw = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    address = 32'h0000_0014;
    wait_ready(40, lat, st);
    chk("pend_first_lat", 32'(lat), 32'd3);
    chk("pend_first_st",  32'(st),  32'(S_ALLOCATE));
    @(posedge clk); #1;
    chk("pend_first_data", data_out, 32'h0000_0010);
    wait_ready(10, lat, st);
    chk("pend_second_lat", 32'(lat), 32'd1);
    chk("pend_second_st",  32'(st),  32'(S_READ_HIT));
    @(posedge clk); #1;
    chk("pend_second_data", data_out, 32'h0000_0014);
    $display("access pending pair 0x00000010 -> 0x00000014 data_out=0x%08h", data_out);

    // Reset in the middle of a miss: no completion, cache emptied.
    @(negedge clk);
    address = 32'h0000_0020; rw = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1; address = '0; rw = 1'b0; data_in = '0;
    @(negedge clk);
    rst = 1'b0;
    chk("midrst_state", 32'(dut.current_state), 32'(S_IDLE));
    chk("midrst_data",  data_out, 32'h0);
    wait_ready(10, lat, st);
    chk("midrst_no_ready", 32'(lat), 32'hFFFF_FFFF);

    access(32'h8001_0000, 1'b0, 32'h0, lat, st, dout);
    chk("post_rst_miss_lat",  32'(lat), 32'd5);
    chk("post_rst_miss_data", dout, 32'h8001_0000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
